// File: rtl/theta_slice_engine_if.sv
// Slice-stream handshake between the round sequencer (master) and the theta engine (slave).
// The out_stall signal exists only when THETA_STALL_EN is defined.
interface theta_slice_engine_if;
  logic        start;
  logic [24:0] in;
  logic        ready;
  logic        put_input;
  logic        out_ready;
  logic [24:0] out;
`ifdef THETA_STALL_EN
  logic        out_stall;

  modport master (
    output start, in, out_stall,
    input  ready, put_input, out_ready, out
  );
  modport slave (
    input  start, in, out_stall,
    output ready, put_input, out_ready, out
  );
`else
  modport master (
    output start, in,
    input  ready, put_input, out_ready, out
  );
  modport slave (
    input  start, in,
    output ready, put_input, out_ready, out
  );
`endif
endinterface

// File: rtl/theta_slice_engine.sv
// Keccak theta step on a 25 x LANE_W state, streamed in and out one 25-bit slice per cycle.
// Optional output back-pressure (out_stall) is enabled by defining THETA_STALL_EN.
module theta_slice_engine #(
  parameter int unsigned LANE_W = 64,
  parameter int unsigned CNT_W  = (LANE_W > 1) ? $clog2(LANE_W) : 1
) (
  input logic                 clk,
  input logic                 rst,
  theta_slice_engine_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StEmit} state_e;

  localparam logic [CNT_W-1:0] LastZ = CNT_W'(LANE_W - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       cprev_q;
  logic             put_input_q;
  logic             out_ready_q;
  logic [24:0]      out_q;
  logic [24:0]      store_q [LANE_W];

  function automatic logic [4:0] col_parity(input logic [24:0] s);
    logic [4:0] p;
    for (int x = 0; x < 5; x++) begin
      p[x] = s[x] ^ s[x+5] ^ s[x+10] ^ s[x+15] ^ s[x+20];
    end
    return p;
  endfunction

  function automatic logic [24:0] theta(input logic [24:0] s, input logic [4:0] cp);
    logic [4:0]  c;
    logic [4:0]  d;
    logic [24:0] r;
    c = col_parity(s);
    for (int x = 0; x < 5; x++) begin
      d[x] = c[(x+4)%5] ^ cp[(x+1)%5];
    end
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        r[x+5*y] = s[x+5*y] ^ d[x];
      end
    end
    return r;
  endfunction

  logic             stall;
  logic [CNT_W-1:0] cnt_nxt;
  logic [24:0]      slice0;
  logic [4:0]       c_last;
  logic [24:0]      next_slice;

`ifdef THETA_STALL_EN
  assign stall = bus.out_stall;
`else
  assign stall = 1'b0;
`endif

  assign cnt_nxt    = cnt_q + 1'b1;
  // Slice 0 output is formed on the last load edge, while slice LANE_W-1 is still on the input.
  assign slice0     = (LANE_W == 1) ? bus.in : store_q[0];
  assign c_last     = col_parity(bus.in);
  assign next_slice = store_q[cnt_nxt];

  always_ff @(posedge clk) begin
    if (state_q == StLoad) begin
      store_q[cnt_q] <= bus.in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cprev_q     <= '0;
      put_input_q <= 1'b0;
      out_ready_q <= 1'b0;
      out_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q     <= StLoad;
            put_input_q <= 1'b1;
            cnt_q       <= '0;
          end
        end
        StLoad: begin
          cnt_q <= cnt_nxt;
          if (cnt_q == LastZ) begin
            state_q     <= StEmit;
            put_input_q <= 1'b0;
            cnt_q       <= '0;
            out_ready_q <= 1'b1;
            out_q       <= theta(slice0, c_last);
            cprev_q     <= col_parity(slice0);
          end
        end
        StEmit: begin
          if (!stall) begin
            if (cnt_q == LastZ) begin
              state_q     <= StIdle;
              cnt_q       <= '0;
              out_ready_q <= 1'b0;
              out_q       <= '0;
            end else begin
              cnt_q   <= cnt_nxt;
              out_q   <= theta(next_slice, cprev_q);
              cprev_q <= col_parity(next_slice);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ready     = (state_q == StIdle);
  assign bus.put_input = put_input_q;
  assign bus.out_ready = out_ready_q;
  assign bus.out       = out_q;

endmodule

// File: tb/tb_theta_slice_engine.sv
// Scoreboard bench for theta_slice_engine: directed states with hand-computed expected slices.
// With THETA_STALL_EN defined it runs an 8-slice build and adds the stall scenarios.
module tb_theta_slice_engine;
`ifdef THETA_STALL_EN
  localparam int L = 8;
`else
  localparam int L = 64;
`endif
  localparam int RstZ = (L > 10) ? 10 : L / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall_v = 1'b0;
  always #5 clk = ~clk;

  theta_slice_engine_if bus ();

  theta_slice_engine #(.LANE_W(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef THETA_STALL_EN
  assign bus.out_stall = stall_v;
`endif

  int          checks = 0;
  int          fails  = 0;
  logic [24:0] exp_q [$];
  logic [24:0] stim  [L];
  logic [24:0] ex    [L];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares every presented slice against the scoreboard head; pops on delivery.
  always @(negedge clk) begin
    if (!rst) begin
      check("put_input/out_ready exclusive", 32'(bus.put_input & bus.out_ready), 32'd0);
      if (bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected out_ready", 32'd1, 32'd0);
        end else begin
          check("out slice", 32'(bus.out), 32'(exp_q[0]));
          if (!stall_v) void'(exp_q.pop_front());
        end
      end else begin
        check("out zero when idle", 32'(bus.out), 32'd0);
      end
    end
  end

  task automatic clear_vectors();
    for (int z = 0; z < L; z++) begin
      stim[z] = '0;
      ex[z]   = '0;
    end
  endtask

  task automatic push_expected();
    for (int z = 0; z < L; z++) exp_q.push_back(ex[z]);
  endtask

  task automatic run(input int stall_z, input int stall_n, input bit pulse_start);
    int oc;
    int z;
    int left;
    int cyc;
    check("ready before start", 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < L; i++) begin
      check("put_input during load", 32'(bus.put_input), 32'd1);
      bus.in = stim[i];
      @(posedge clk); #1;
    end
    bus.in = '0;
    check("put_input after load", 32'(bus.put_input), 32'd0);
    check("first out_ready latency", 32'(bus.out_ready), 32'd1);
    oc   = 0;
    z    = 0;
    left = stall_n;
    cyc  = 0;
    while (bus.out_ready && cyc < 4 * L) begin
      stall_v = (z == stall_z) && (left > 0);
      if (stall_v) left--;
      bus.start = pulse_start && (z == 2);
      @(negedge clk);
      oc++;
      if (!stall_v) z++;
      @(posedge clk); #1;
      cyc++;
    end
    stall_v   = 1'b0;
    bus.start = 1'b0;
    check("out_ready cycle count", 32'(oc), 32'(L + stall_n));
    check("ready after emit", 32'(bus.ready), 32'd1);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    check("no restart after emit", 32'(bus.put_input), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.in    = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 32'(bus.ready), 32'd1);
    check("reset put_input", 32'(bus.put_input), 32'd0);
    check("reset out_ready", 32'(bus.out_ready), 32'd0);
    check("reset out", 32'(bus.out), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // All-zero state
    clear_vectors();
    push_expected();
    run(-1, 0, 1'b0);

    // Single bit in slice 0, with a start pulse while emitting
    clear_vectors();
    stim[0] = 25'h0000001;
    ex[0]   = 25'h0210843;
    ex[1]   = 25'h1084210;
    push_expected();
    run(-1, 0, 1'b1);

    // Wrap-around: last slice feeds slice 0 through c_last
    clear_vectors();
    stim[L-1] = 25'h0000001;
    ex[0]     = 25'h1084210;
    ex[L-1]   = 25'h0210843;
    push_expected();
    run(-1, 0, 1'b0);

    // Even column parity leaves the state untouched
    clear_vectors();
    stim[5] = 25'h0000021;
    ex[5]   = 25'h0000021;
    push_expected();
    run(-1, 0, 1'b0);

    // Reset in the middle of a load
    clear_vectors();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < RstZ; i++) begin
      bus.in = 25'h1555555;
      @(posedge clk); #1;
    end
    check("put_input before abort", 32'(bus.put_input), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort ready", 32'(bus.ready), 32'd1);
    check("abort put_input", 32'(bus.put_input), 32'd0);
    check("abort out_ready", 32'(bus.out_ready), 32'd0);
    rst    = 1'b0;
    bus.in = '0;
    repeat (L + 4) @(posedge clk);
    #1;
    check("idle after abort", 32'(bus.ready), 32'd1);

    // Fresh single-bit run after the abort
    clear_vectors();
    stim[0] = 25'h0000001;
    ex[0]   = 25'h0210843;
    ex[1]   = 25'h1084210;
    push_expected();
    run(-1, 0, 1'b0);

`ifdef THETA_STALL_EN
    // Stall three cycles on slice 1, then on slice 0 (c_last boundary)
    push_expected();
    run(1, 3, 1'b0);
    push_expected();
    run(0, 3, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
